// File: rtl/fetch_decode_sequencer_pkg.sv
// Shared types and constants for the fetch/decode sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT     = 3'd2,
    S_ISSUE_LO = 3'd3,
    S_ISSUE_HI = 3'd4,
    S_DONE     = 3'd5
  } fetch_state_t;

  localparam int unsigned INST_WIDTH = 32;

  // Word index within a beat; the low half is the lower-addressed instruction.
  localparam int unsigned HALF_LO = 0;
  localparam int unsigned HALF_HI = 1;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned BEAT_BYTES = 8;

endpackage

// File: rtl/fetch_decode_sequencer_if.sv
// Memory-bus and instruction-issue handshake bundle for the fetch sequencer.
interface fetch_decode_sequencer_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH     = 64
);
  localparam int unsigned INST_WIDTH = BUS_DATA_WIDTH / 2;

  logic [ADDR_WIDTH-1:0]     bus_req;
  logic                      bus_reqcyc;
  logic                      bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic                      bus_respcyc;
  logic                      bus_respack;

  logic [INST_WIDTH-1:0]     inst;
  logic [ADDR_WIDTH-1:0]     inst_pc;
  logic                      inst_valid;
  logic                      inst_ready;

  modport master (
    output bus_req, bus_reqcyc, bus_respack, inst, inst_pc, inst_valid,
    input  bus_reqack, bus_resp, bus_respcyc, inst_ready
  );

  modport slave (
    input  bus_req, bus_reqcyc, bus_respack, inst, inst_pc, inst_valid,
    output bus_reqack, bus_resp, bus_respcyc, inst_ready
  );

endinterface

// File: rtl/fetch_decode_sequencer.sv
// Fetches 64-bit beats from an entry PC and issues their two 32-bit words
// in order to the decoder until the first all-zero word.
module fetch_decode_sequencer #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned INST_WIDTH     = fetch_pkg::INST_WIDTH,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      entry_pc,
  fetch_decode_sequencer_if.master   bus,
  output logic                       busy,
  output logic                       done,
  output logic [COUNT_WIDTH-1:0]     inst_count
);
  import fetch_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] INST_MASK = ~ADDR_WIDTH'(INST_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(INST_BYTES);

  fetch_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic [BUS_DATA_WIDTH-1:0] buf_q, buf_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;

  logic [ADDR_WIDTH-1:0]     bus_req_q;
  logic                      bus_reqcyc_q;
  logic [INST_WIDTH-1:0]     inst_q;
  logic [ADDR_WIDTH-1:0]     inst_pc_q;
  logic                      inst_valid_q;
  logic                      busy_q;
  logic                      done_q;

  logic [INST_WIDTH-1:0]     cur_word;
  logic [INST_WIDTH-1:0]     nxt_word;
  logic                      nxt_issue;
  logic                      nxt_valid;

  // Next-state and datapath updates; outputs are later registered from these.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    count_d  = count_q;
    cur_word = (state_q == S_ISSUE_HI) ? buf_q[HALF_HI*INST_WIDTH +: INST_WIDTH]
                                       : buf_q[HALF_LO*INST_WIDTH +: INST_WIDTH];
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = entry_pc & INST_MASK;
          count_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.bus_reqack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.bus_respcyc) begin
          buf_d   = bus.bus_resp;
          state_d = pc_q[2] ? S_ISSUE_HI : S_ISSUE_LO;
        end
      end
      S_ISSUE_LO, S_ISSUE_HI: begin
        // A zero word terminates the program without being issued.
        if (cur_word == '0) begin
          state_d = S_DONE;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + PC_STEP;
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = (state_q == S_ISSUE_LO) ? S_ISSUE_HI : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue view of the upcoming state, so issue outputs can be registered.
  always_comb begin
    nxt_word  = (state_d == S_ISSUE_HI) ? buf_d[HALF_HI*INST_WIDTH +: INST_WIDTH]
                                        : buf_d[HALF_LO*INST_WIDTH +: INST_WIDTH];
    nxt_issue = (state_d == S_ISSUE_LO) || (state_d == S_ISSUE_HI);
    nxt_valid = nxt_issue && (nxt_word != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      buf_q        <= '0;
      count_q      <= '0;
      bus_req_q    <= '0;
      bus_reqcyc_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      bus_req_q    <= pc_d & BEAT_MASK;
      bus_reqcyc_q <= (state_d == S_REQ);
      inst_q       <= nxt_valid ? nxt_word : '0;
      inst_pc_q    <= nxt_valid ? pc_d : '0;
      inst_valid_q <= nxt_valid;
      busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
    end
  end

  // Responses are always consumed; outside WAIT the data is simply dropped.
  assign bus.bus_respack = bus.bus_respcyc;

  assign bus.bus_req    = bus_req_q;
  assign bus.bus_reqcyc = bus_reqcyc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign inst_count     = count_q;

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// Self-checking bench: table of programs run against a memory model, with a
// scoreboard of expected issues and request addresses, plus a mid-issue reset.
module tb_fetch_decode_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] entry_pc;
  logic        busy;
  logic        done;
  logic [31:0] inst_count;

  fetch_decode_sequencer_if #(.BUS_DATA_WIDTH(64), .ADDR_WIDTH(64)) bus_if ();

  fetch_decode_sequencer #(
    .BUS_DATA_WIDTH(64), .ADDR_WIDTH(64), .INST_WIDTH(32), .COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc),
    .bus(bus_if), .busy(busy), .done(done), .inst_count(inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] entry;
    logic [63:0] b0;
    logic [63:0] b1;
    logic [63:0] b2;
    int          ack_d;
    int          resp_d;
    int          stall;
    int          exp_count;
    logic [63:0] exp_req0;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
  } exp_t;

  vec_t        tbl[6];
  exp_t        exp_q[$];
  logic [63:0] req_q[$];
  logic [63:0] mem [logic [63:0]];

  int n_chk = 0;
  int n_fail = 0;

  int          ack_delay, resp_delay, ack_wait, resp_wait, stall_left;
  bit          resp_pending, beat_seen, req_started, first_ack, prev_stall;
  logic [63:0] resp_addr, req_hold, exp_req0, block_pc;
  logic [31:0] prev_inst;
  logic [63:0] prev_pc;
  int          acc, steps, first_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Reference sequence of requests and issued words for a program.
  task automatic build_model(input logic [63:0] e);
    logic [63:0] pc = e & ~64'h3;
    logic [63:0] beat = 64'h0;
    logic [31:0] w;
    bit need_req = 1'b1;
    exp_q.delete();
    req_q.delete();
    for (int k = 0; k < 32; k++) begin
      if (need_req) begin
        req_q.push_back(pc & ~64'h7);
        beat = mem_rd(pc & ~64'h7);
        need_req = 1'b0;
      end
      w = pc[2] ? beat[63:32] : beat[31:0];
      if (w == 32'h0) break;
      exp_q.push_back('{w: w, pc: pc});
      if (pc[2]) need_req = 1'b1;
      pc = pc + 64'd4;
    end
  endtask

  // One cycle of bus/decoder behaviour, evaluated at the falling edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    steps++;
    chk("inst_count_track", 64'(inst_count), 64'(acc));
    if (prev_stall) begin
      chk("hold_inst", 64'(bus_if.inst), 64'(prev_inst));
      chk("hold_inst_pc", bus_if.inst_pc, prev_pc);
    end
    if (bus_if.inst_valid) begin
      chk("valid_after_resp", 64'(beat_seen), 64'd1);
      if (first_valid == 0) first_valid = steps;
    end

    bus_if.bus_respcyc = 1'b0;
    if (resp_pending) begin
      if (resp_wait > 0) resp_wait--;
      else begin
        bus_if.bus_resp    = mem_rd(resp_addr);
        bus_if.bus_respcyc = 1'b1;
        resp_pending       = 1'b0;
        beat_seen          = 1'b1;
      end
    end

    bus_if.bus_reqack = 1'b0;
    if (bus_if.bus_reqcyc) begin
      if (req_started) chk("req_stable", bus_if.bus_req, req_hold);
      if (ack_wait > 0) begin
        ack_wait--;
        req_hold    = bus_if.bus_req;
        req_started = 1'b1;
      end else begin
        if (first_ack) begin
          chk("first_req", bus_if.bus_req, exp_req0);
          first_ack = 1'b0;
        end
        if (req_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL req_unexpected: got request %h, required none", bus_if.bus_req);
        end else begin
          chk("req_addr", bus_if.bus_req, req_q.pop_front());
        end
        bus_if.bus_reqack = 1'b1;
        resp_pending = 1'b1;
        resp_wait    = resp_delay;
        resp_addr    = bus_if.bus_req;
        beat_seen    = 1'b0;
        ack_wait     = ack_delay;
        req_started  = 1'b0;
      end
    end

    prev_stall = 1'b0;
    bus_if.inst_ready = 1'b1;
    if (bus_if.inst_valid) begin
      if (stall_left > 0 || bus_if.inst_pc == block_pc) begin
        bus_if.inst_ready = 1'b0;
        if (stall_left > 0) stall_left--;
        prev_stall = 1'b1;
        prev_inst  = bus_if.inst;
        prev_pc    = bus_if.inst_pc;
      end else if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL issue_unexpected: got inst %h pc %h, required none", bus_if.inst, bus_if.inst_pc);
        acc++;
      end else begin
        e = exp_q.pop_front();
        chk("inst", 64'(bus_if.inst), 64'(e.w));
        chk("inst_pc", bus_if.inst_pc, e.pc);
        acc++;
      end
    end
    #1;
    if (bus_if.bus_respcyc) chk("respack", 64'(bus_if.bus_respack), 64'd1);
  endtask

  task automatic run_entry(input vec_t v);
    int cyc = 0;
    logic [63:0] base = v.entry & ~64'h7;
    mem[base] = v.b0;
    mem[base + 64'd8] = v.b1;
    mem[base + 64'd16] = v.b2;
    build_model(v.entry);
    ack_delay = v.ack_d; resp_delay = v.resp_d; ack_wait = v.ack_d;
    stall_left = v.stall; exp_req0 = v.exp_req0;
    resp_pending = 1'b0; beat_seen = 1'b0; req_started = 1'b0;
    first_ack = 1'b1; prev_stall = 1'b0;
    acc = 0; steps = 0; first_valid = 0;
    start = 1'b1;
    entry_pc = v.entry;
    step();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done_clear", 64'(done), 64'd0);
    chk("start_count_clear", 64'(inst_count), 64'd0);
    while (!done && cyc < 400) begin
      step();
      cyc++;
    end
    chk("reached_done", 64'(done), 64'd1);
    chk("final_count", 64'(inst_count), 64'(v.exp_count));
    chk("first_valid_latency", 64'(first_valid), 64'(v.exp_lat));
    chk("issues_left", 64'(exp_q.size()), 64'd0);
    chk("reqs_left", 64'(req_q.size()), 64'd0);
    chk("done_not_busy", 64'(busy), 64'd0);
    chk("done_no_valid", 64'(bus_if.inst_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus_req"}, bus_if.bus_req, 64'h0);
    chk({tag, "_reqcyc"}, 64'(bus_if.bus_reqcyc), 64'd0);
    chk({tag, "_inst"}, 64'(bus_if.inst), 64'd0);
    chk({tag, "_inst_pc"}, bus_if.inst_pc, 64'h0);
    chk({tag, "_inst_valid"}, 64'(bus_if.inst_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_count"}, 64'(inst_count), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    tbl[0] = '{64'h1000, 64'h00000013_00100093, 64'h0, 64'h0, 0, 0, 0, 2, 64'h1000, 3};
    tbl[1] = '{64'h1004, 64'h00000013_00100093, 64'h0, 64'h0, 0, 0, 0, 1, 64'h1000, 3};
    tbl[2] = '{64'h3000, 64'hAAAA5555_12345678, 64'h00000000_0000BEEF, 64'h0, 0, 0, 5, 3, 64'h3000, 3};
    tbl[3] = '{64'h4002, 64'h11111111_22222222, 64'h44444444_00000000, 64'h0, 3, 4, 0, 2, 64'h4000, 10};
    tbl[4] = '{64'h2000, 64'h00000000_DEADBEEF, 64'h0, 64'h0, 0, 0, 0, 1, 64'h2000, 3};
    tbl[5] = '{64'hFFFFFFFF_FFFFFFF8, 64'h00000002_00000001, 64'h0, 64'h0, 1, 2, 1, 2,
               64'hFFFFFFFF_FFFFFFF8, 6};

    reset = 1'b0; start = 1'b0; entry_pc = 64'h0;
    bus_if.bus_reqack = 1'b0; bus_if.bus_resp = 64'h0;
    bus_if.bus_respcyc = 1'b0; bus_if.inst_ready = 1'b0;
    block_pc = 64'h1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_entry(tbl[i]);

    // Reset while the high word is stalled at the decoder.
    mem[64'h5000] = 64'h00000007_00000005;
    mem[64'h5008] = 64'h00000009_00000008;
    build_model(64'h5000);
    ack_delay = 0; resp_delay = 0; ack_wait = 0; stall_left = 0;
    resp_pending = 1'b0; beat_seen = 1'b0; req_started = 1'b0;
    first_ack = 1'b0; prev_stall = 1'b0; acc = 0; steps = 0; first_valid = 0;
    block_pc = 64'h5004;
    start = 1'b1; entry_pc = 64'h5000;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(bus_if.inst_valid && bus_if.inst_pc == 64'h5004) && cyc < 50) begin
      step();
      cyc++;
    end
    chk("reached_issue_hi", bus_if.inst_pc, 64'h5004);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    reset = 1'b1;
    exp_q.delete(); req_q.delete();
    block_pc = 64'h1; acc = 0; prev_stall = 1'b0; resp_pending = 1'b0;
    bus_if.bus_resp = 64'hCAFEF00D_12345678;
    bus_if.bus_respcyc = 1'b1;
    #1;
    chk("stray_respack", 64'(bus_if.bus_respack), 64'd1);
    @(negedge clk);
    bus_if.bus_respcyc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stray_no_valid", 64'(bus_if.inst_valid), 64'd0);
      chk("stray_no_req", 64'(bus_if.bus_reqcyc), 64'd0);
      chk("stray_idle", 64'(busy), 64'd0);
      @(negedge clk);
    end

    run_entry(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_sequencer.md
# fetch_decode_sequencer

Sequences instruction fetch for the decode stage. On `start` it reads 64-bit beats from the memory bus, starting at an entry PC. It splits each beat into two 32-bit instruction words, low half first, and presents them one at a time with their PC over a valid/ready handshake to the stage that drives `process_instruction`. The first all-zero instruction word ends the program.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, bus beat width; holds exactly two instructions
- ADDR_WIDTH, 64, PC and bus address width
- INST_WIDTH, 32, instruction word width; fixed at BUS_DATA_WIDTH/2
- COUNT_WIDTH, 32, issued-instruction counter width

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches `entry_pc` and begins fetch
- entry_pc  in  ADDR_WIDTH  first instruction address; bits [1:0] ignored
- bus_req  out  ADDR_WIDTH  beat address, always 8-byte aligned
- bus_reqcyc  out  1  request valid
- bus_reqack  in  1  request accepted
- bus_resp  in  BUS_DATA_WIDTH  response beat
- bus_respcyc  in  1  response valid
- bus_respack  out  1  response consumed
- inst  out  INST_WIDTH  instruction word to the decoder
- inst_pc  out  ADDR_WIDTH  PC of `inst`
- inst_valid  out  1  `inst` and `inst_pc` are valid
- inst_ready  in  1  downstream accepts `inst`
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  zero word reached; held until the next `start`
- inst_count  out  COUNT_WIDTH  instructions accepted since the last `start`

## Operation
States are IDLE, REQ, WAIT, ISSUE_LO, ISSUE_HI and DONE.
- IDLE/DONE:
  - `start` loads pc ← {entry_pc[63:2], 2'b00}, clears `inst_count` and `done`, and moves to REQ.
  - `start` in any other state is ignored.
- REQ:
  - `bus_reqcyc` = 1 and `bus_req` = {pc[63:3], 3'b000}, both held until `bus_reqack`.
  - On `bus_reqack`, move to WAIT.
- WAIT:
  - On `bus_respcyc`, latch `bus_resp` into the beat buffer and drive `bus_respack` = 1 combinationally in that cycle.
  - Next state is ISSUE_HI if pc[2] = 1, otherwise ISSUE_LO.
- ISSUE_LO / ISSUE_HI:
  - The word is buffer[31:0] in ISSUE_LO and buffer[63:32] in ISSUE_HI.
  - If the word is 32'h0, go to DONE. `inst_valid` stays 0, and the zero word is neither issued nor counted.
  - Otherwise `inst_valid` = 1 and `inst_pc` = pc.
  - On `inst_valid` && `inst_ready`: pc ← pc + 4 and `inst_count` ← `inst_count` + 1 (wraps modulo 2^COUNT_WIDTH).
  - After that handshake, ISSUE_LO moves to ISSUE_HI and ISSUE_HI moves to REQ.
- Backpressure: while `inst_valid` && !`inst_ready`, `inst` and `inst_pc` are held stable.
- `bus_respcyc` outside WAIT is acked with `bus_respack` = 1 and the data is discarded. This covers responses still in flight after a reset.
- PC arithmetic wraps modulo 2^ADDR_WIDTH; there is no fault on wrap.

## Timing
Reset values (reset = 0 sampled at an edge):
- State returns to IDLE from any state, including mid-request or mid-issue.
- pc, buffer and `inst_count` are cleared.
- `bus_reqcyc`, `inst_valid`, `busy` and `done` are 0.
- `bus_req`, `inst` and `inst_pc` are 0.

Cycle behaviour:
- `start` is sampled at edge T; `bus_reqcyc` is high from cycle T+1.
- With ack and response each arriving in the first cycle they can, the first `inst_valid` appears 3 cycles after `start`.
- Steady state with `inst_ready` tied high: 2 instructions per 4 cycles (REQ, WAIT, LO, HI).
- `inst_valid`, `inst`, `inst_pc`, `busy`, `done` and `bus_reqcyc` are registered from state and buffer, with no combinational path from inputs.
- `bus_respack` is the only combinational output.
- `done` rises in the cycle after the ISSUE state that finds the zero word.

## Structure
Shared package `fetch_pkg` holds:
- the state enum `fetch_state_t`
- INST_WIDTH and the beat-half select constants
- the instruction-size constant (4) and the beat-size constant (8)

There are no sub-modules: one FSM plus a beat buffer and counters, about 200 lines. The decoder is instantiated by the parent, downstream of `inst`/`inst_valid`.

## Test plan
- **Basic run.** entry_pc = 0x1000; beat 0x00000013_00100093 at 0x1000, then beat 0x0 at 0x1008.
  - Issues 0x00100093 @0x1000 and 0x00000013 @0x1004.
  - Next request at 0x1008, then `done` = 1 and `inst_count` = 2.
- **Odd entry.** entry_pc = 0x1004.
  - First request is to 0x1000.
  - Only the high word is issued, with `inst_pc` = 0x1004.
- **Backpressure.** `inst_ready` held low for 5 cycles with `inst_valid` high.
  - `inst` and `inst_pc` stay unchanged.
  - `inst_count` increments exactly once after `inst_ready` rises.
- **Bus stalls.** `bus_reqack` delayed 3 cycles and `bus_respcyc` delayed 4 cycles.
  - `bus_req` stays stable throughout.
  - No `inst_valid` before the response arrives.
- **Reset mid-issue.** reset = 0 during ISSUE_HI, then a stray `bus_respcyc`.
  - After reset, all outputs are 0 and the state is IDLE.
  - The stray response gets `bus_respack` = 1 and nothing is issued.
- **Restart after done.** A second `start` with entry_pc = 0x2000.
  - `inst_count` restarts at 0 and `done` clears in the next cycle.
  - Fetch begins at 0x2000.
